p2s_serializer: RTL and testbench
=================================

Name: p2s_serializer

Overview:
- Downstream consumer of the pipelined FIFO: drives `pop`, waits the FIFO's fixed pop-to-data latency, then captures `pop_data`.
- Shifts each captured word out one bit per accepted beat on a valid/ready serial interface.
- Holds one word in a prefetch register so consecutive words stream back-to-back with no idle beat.

Parameters:
- FIFO_WIDTH, 11, word width; must equal the upstream FIFO's FIFO_WIDTH.
- NUM_LOOPS, 3, pop-to-`pop_data` latency of the upstream FIFO in cycles (>=1).
- MSB_FIRST, 1, 1 = transmit bit FIFO_WIDTH-1 first; 0 = bit 0 first.
- CNT_WIDTH, 16, width of the `words_sent` counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- empty  in  1  upstream FIFO empty flag.
- pop  out  1  pop request to upstream FIFO.
- pop_data  in  FIFO_WIDTH  upstream data, valid exactly NUM_LOOPS cycles after `pop`.
- ser_ready  in  1  downstream accepts the current bit.
- sdata  out  1  serial data bit.
- svalid  out  1  `sdata` is valid.
- sfirst  out  1  current bit is the first bit of a word.
- slast  out  1  current bit is the last bit of a word.
- words_sent  out  CNT_WIDTH  count of fully transmitted words; wraps.

Behaviour:
- Reset (async, while `rst`=1): all outputs are 0; shift register, bit counter, `hold_valid`, in-flight delay line and `words_sent` are cleared. Reset mid-word discards the in-flight, held and shifting words; the upstream FIFO is reset in the same domain.
- Pop rule: `pop` = !empty && !inflight && !hold_valid. It is combinational from registered state and `empty`, and is never asserted while `rst`=1.
- inflight = OR of a NUM_LOOPS-bit delay line that shifts in `pop` each cycle. At most one pop is outstanding.
- Capture: when `pop` is high in cycle c, `pop_data` is sampled at the end of cycle c+NUM_LOOPS.
  - If the shifter is free at that edge, the word loads into the shifter. Free means `svalid`=0, or `svalid`&&`slast`&&`ser_ready`.
  - Otherwise the word loads into the hold register and `hold_valid` is set.
  - The hold register cannot overflow, because pop requires !hold_valid and !inflight.
- Transfer beat = `svalid` && `ser_ready`. On a beat the shifter advances one bit (left if MSB_FIRST, else right) and the bit counter increments.
- `sdata` = current MSB (or LSB if MSB_FIRST=0) of the shifter. `sfirst` = (bit counter == 0). `slast` = (bit counter == FIFO_WIDTH-1).
- Without a beat, `sdata`, `sfirst` and `slast` hold stable while `svalid`=1. The bit is never dropped or repeated.
- End of word (beat with `slast`):
  - `words_sent` increments.
  - If `hold_valid`, the hold word loads into the shifter at the same edge, `hold_valid` clears, and `svalid` stays 1 with `sfirst` next cycle.
  - Else, if a capture happens at the same edge, that word loads directly.
  - Else `svalid` drops to 0.
- States: IDLE (no word), SHIFT (word in shifter). Hold and in-flight are orthogonal flags.
- Latency: pop in cycle c gives the first bit with `svalid` in cycle c+NUM_LOOPS+1, provided the shifter is free.
- Throughput: gap-free when FIFO_WIDTH > NUM_LOOPS+1. Otherwise idle beats between words are permitted.
- `empty` rising while a pop is in flight has no effect; that word is still captured.
- `ser_ready` low indefinitely: prefetch fills the hold register, then `pop` stays 0.

Test Plan:
- One word, NUM_LOOPS=3, MSB_FIRST=1, `ser_ready`=1: FIFO delivers 11'h5A3 → `pop` in cycle 0; `svalid` in cycles 4..14; bits 1,0,1,1,0,1,0,0,0,1,1; `sfirst` in cycle 4, `slast` in cycle 14; `words_sent`=1; `svalid`=0 in cycle 15.
- Back-to-back: FIFO holds 11'h001 and 11'h7FF → second `pop` in cycle 4, held by cycle 8; `svalid` continuous in cycles 4..25; `sfirst` in cycle 15; `words_sent`=2.
- Backpressure: `ser_ready` toggles 1,0 from cycle 4 → each bit is held 2 cycles, order unchanged; with 3 words queued, `pop` stays 0 while hold is full.
- MSB_FIRST=0 with 11'h001 → first bit 1, then ten 0s.
- Reset mid-word: assert `rst` during bit 5 → all outputs 0 in the same cycle; after release, no spurious `svalid` and `pop` waits for !empty.
- Empty FIFO (`empty`=1 throughout) → `pop` and `svalid` never assert; `words_sent` stays 0.

Source files
------------

// File: rtl/p2s_serializer.sv
// Parallel-to-serial converter fed by a fixed-latency pipelined FIFO.
// One word is prefetched into a hold register so words stream back-to-back.
//
// state   | meaning
// S_IDLE  | shifter empty, svalid low
// S_SHIFT | shifter holds a word, svalid high
module p2s_serializer #(
  parameter int FIFO_WIDTH = 11,
  parameter int NUM_LOOPS  = 3,
  parameter bit MSB_FIRST  = 1'b1,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  empty,
  output logic                  pop,
  input  logic [FIFO_WIDTH-1:0] pop_data,
  input  logic                  ser_ready,
  output logic                  sdata,
  output logic                  svalid,
  output logic                  sfirst,
  output logic                  slast,
  output logic [CNT_WIDTH-1:0]  words_sent
);

  localparam int BIT_W = (FIFO_WIDTH > 1) ? $clog2(FIFO_WIDTH) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FIFO_WIDTH - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [FIFO_WIDTH-1:0] r_shift;
  logic [FIFO_WIDTH-1:0] w_shift_nxt;
  logic [FIFO_WIDTH-1:0] r_hold;
  logic [FIFO_WIDTH-1:0] w_hold_nxt;
  logic                  r_hold_valid;
  logic                  w_hold_valid_nxt;
  logic [BIT_W-1:0]      r_bit_cnt;
  logic [BIT_W-1:0]      w_bit_cnt_nxt;
  logic [CNT_WIDTH-1:0]  r_words;
  logic [CNT_WIDTH-1:0]  w_words_nxt;
  logic [NUM_LOOPS-1:0]  r_dly;

  logic w_inflight;
  logic w_capture;
  logic w_beat;
  logic w_end;
  logic w_free;

  // Delay line mirrors the FIFO read pipeline; its last tap marks pop_data valid.
  if (NUM_LOOPS == 1) begin : g_dly_one
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_dly <= '0;
      end else begin
        r_dly <= pop;
      end
    end
  end else begin : g_dly_multi
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_dly <= '0;
      end else begin
        r_dly <= {r_dly[NUM_LOOPS-2:0], pop};
      end
    end
  end

  assign w_inflight = |r_dly;
  assign w_capture  = r_dly[NUM_LOOPS-1];

  assign pop = !rst && !empty && !w_inflight && !r_hold_valid;

  assign svalid     = (r_state == S_SHIFT);
  assign sfirst     = svalid && (r_bit_cnt == '0);
  assign slast      = svalid && (r_bit_cnt == LAST_BIT);
  assign sdata      = svalid && (MSB_FIRST ? r_shift[FIFO_WIDTH-1] : r_shift[0]);
  assign words_sent = r_words;

  assign w_beat = svalid && ser_ready;
  assign w_end  = w_beat && slast;
  assign w_free = !svalid || w_end;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_shift      <= '0;
      r_hold       <= '0;
      r_hold_valid <= 1'b0;
      r_bit_cnt    <= '0;
      r_words      <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_shift      <= w_shift_nxt;
      r_hold       <= w_hold_nxt;
      r_hold_valid <= w_hold_valid_nxt;
      r_bit_cnt    <= w_bit_cnt_nxt;
      r_words      <= w_words_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_shift_nxt      = r_shift;
    w_hold_nxt       = r_hold;
    w_hold_valid_nxt = r_hold_valid;
    w_bit_cnt_nxt    = r_bit_cnt;
    w_words_nxt      = r_words;

    if (w_beat) begin
      w_shift_nxt   = MSB_FIRST ? (r_shift << 1) : (r_shift >> 1);
      w_bit_cnt_nxt = r_bit_cnt + BIT_W'(1);
    end

    if (w_end) begin
      w_words_nxt = r_words + CNT_WIDTH'(1);
    end

    // Held word has priority over a fresh capture when the shifter frees up.
    if (w_free) begin
      if (r_hold_valid) begin
        w_shift_nxt      = r_hold;
        w_bit_cnt_nxt    = '0;
        w_state_nxt      = S_SHIFT;
        w_hold_valid_nxt = 1'b0;
        if (w_capture) begin
          w_hold_nxt       = pop_data;
          w_hold_valid_nxt = 1'b1;
        end
      end else if (w_capture) begin
        w_shift_nxt   = pop_data;
        w_bit_cnt_nxt = '0;
        w_state_nxt   = S_SHIFT;
      end else if (w_end) begin
        w_bit_cnt_nxt = '0;
        w_state_nxt   = S_IDLE;
      end
    end else if (w_capture) begin
      w_hold_nxt       = pop_data;
      w_hold_valid_nxt = 1'b1;
    end
  end

endmodule

// File: tb/tb_p2s_serializer.sv
// Directed bench for p2s_serializer: FIFO model with fixed read latency,
// per-bit scoreboard for an MSB-first and an LSB-first instance.
module tb_p2s_serializer;

  localparam int W  = 11;
  localparam int NL = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          empty;
  logic [W-1:0]  pop_data;
  logic          ser_ready;

  logic          pop,   sdata,   svalid,   sfirst,   slast;
  logic          pop_b, sdata_b, svalid_b, sfirst_b, slast_b;
  logic [15:0]   words_sent, words_sent_b;

  typedef struct {
    logic d;
    logic f;
    logic l;
  } exp_t;

  exp_t         exp_a[$];
  exp_t         exp_b[$];
  logic [W-1:0] fifo_q[$];
  logic [W-1:0] pipe [NL];
  logic         stage_v = 1'b0;
  logic [W-1:0] stage_w;
  int           n_tests = 0;
  int           n_fail  = 0;
  int           model_ws = 0;
  logic         prev_stall = 1'b0;
  logic         prev_d, prev_f, prev_l;

  always #5 clk = ~clk;

  p2s_serializer #(.FIFO_WIDTH(W), .NUM_LOOPS(NL), .MSB_FIRST(1'b1), .CNT_WIDTH(16)) u_dut (
    .clk(clk), .rst(rst), .empty(empty), .pop(pop), .pop_data(pop_data),
    .ser_ready(ser_ready), .sdata(sdata), .svalid(svalid), .sfirst(sfirst),
    .slast(slast), .words_sent(words_sent)
  );

  p2s_serializer #(.FIFO_WIDTH(W), .NUM_LOOPS(NL), .MSB_FIRST(1'b0), .CNT_WIDTH(16)) u_dut_lsb (
    .clk(clk), .rst(rst), .empty(empty), .pop(pop_b), .pop_data(pop_data),
    .ser_ready(ser_ready), .sdata(sdata_b), .svalid(svalid_b), .sfirst(sfirst_b),
    .slast(slast_b), .words_sent(words_sent_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_tests++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic fifo_push(input logic [W-1:0] w);
    fifo_q.push_back(w);
    empty = 1'b0;
  endtask

  task automatic push_exp(input logic [W-1:0] w);
    for (int i = 0; i < W; i++) begin
      exp_a.push_back('{d: w[W-1-i], f: (i == 0), l: (i == W-1)});
      exp_b.push_back('{d: w[i],     f: (i == 0), l: (i == W-1)});
    end
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while ((exp_a.size() != 0 || svalid || fifo_q.size() != 0 || stage_v) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, (n < budget), 1);
  endtask

  // FIFO read pipeline: a word popped in cycle c appears on pop_data in cycle c+NL.
  always @(posedge clk) begin
    #1;
    if (rst) begin
      for (int i = 0; i < NL; i++) pipe[i] = W'($urandom);
    end else begin
      for (int i = NL-1; i > 0; i--) pipe[i] = pipe[i-1];
      pipe[0] = stage_v ? stage_w : W'($urandom);
    end
    stage_v  = 1'b0;
    pop_data = pipe[NL-1];
    empty    = (fifo_q.size() == 0);
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_stall = 1'b0;
      stage_v    = 1'b0;
      model_ws   = 0;
      exp_a.delete();
      exp_b.delete();
    end else begin
      check("pop_lsb_match", pop_b, pop);
      check("words_sent", words_sent, model_ws);
      check("words_sent_lsb", words_sent_b, model_ws);
      if (prev_stall)
        check("stall_hold", {svalid, sdata, sfirst, slast}, {1'b1, prev_d, prev_f, prev_l});
      if (pop) begin
        check("pop_nonempty", (fifo_q.size() != 0), 1);
        if (fifo_q.size() != 0) begin
          stage_w = fifo_q.pop_front();
          stage_v = 1'b1;
          push_exp(stage_w);
        end
      end
      if (svalid && ser_ready) begin
        check("beat_expected", (exp_a.size() != 0), 1);
        if (exp_a.size() != 0) begin
          e = exp_a.pop_front();
          check("bit_msb", {sdata, sfirst, slast}, {e.d, e.f, e.l});
          if (e.l) model_ws++;
        end
      end
      if (svalid_b && ser_ready) begin
        check("beat_expected_lsb", (exp_b.size() != 0), 1);
        if (exp_b.size() != 0) begin
          e = exp_b.pop_front();
          check("bit_lsb", {sdata_b, sfirst_b, slast_b}, {e.d, e.f, e.l});
        end
      end
      prev_stall = svalid && !ser_ready;
      prev_d = sdata;
      prev_f = sfirst;
      prev_l = slast;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; empty = 1'b1; ser_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs", {pop, svalid, sdata, sfirst, slast}, 0);
    check("reset_outputs_lsb", {pop_b, svalid_b, sdata_b, sfirst_b, slast_b}, 0);
    check("reset_words", words_sent, 0);

    // Empty FIFO: nothing moves.
    @(posedge clk); #1; rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("empty_idle", {pop, svalid}, 0);
    end

    // Single word 5A3, full-rate sink.
    @(posedge clk); #1; fifo_push(11'h5A3);
    for (int k = 0; k <= 15; k++) begin
      @(negedge clk);
      check("one_pop", pop, (k == 0));
      check("one_svalid", svalid, (k >= 4 && k <= 14));
      if (k == 4)  check("one_sfirst", sfirst, 1);
      if (k == 14) check("one_slast", slast, 1);
      if (k == 15) check("one_words", words_sent, 1);
    end

    // Back-to-back 001 then 7FF via the hold register.
    @(posedge clk); #1; fifo_push(11'h001); fifo_push(11'h7FF);
    for (int k = 0; k <= 26; k++) begin
      @(negedge clk);
      check("b2b_pop", pop, (k == 0 || k == 4));
      check("b2b_svalid", svalid, (k >= 4 && k <= 25));
      if (k >= 4 && k <= 25) check("b2b_sfirst", sfirst, (k == 4 || k == 15));
      if (k == 4) begin
        check("b2b_msb_first_bit", sdata, 0);
        check("b2b_lsb_first_bit", sdata_b, 1);
      end
      if (k == 5) check("b2b_lsb_second_bit", sdata_b, 0);
      if (k == 26) check("b2b_words", words_sent, 3);
    end

    // Backpressure: ready toggles from cycle 4; third pop waits for hold to drain.
    @(posedge clk); #1;
    fifo_push(11'h2AA); fifo_push(11'h155); fifo_push(11'h6C3);
    ser_ready = 1'b1;
    for (int k = 0; k <= 25; k++) begin
      @(negedge clk);
      check("bp_pop", pop, (k == 0 || k == 4 || k == 25));
      @(posedge clk); #1;
      ser_ready = ((k + 1) < 4) ? 1'b1 : (((k + 1) % 2) == 0);
    end
    drain("bp_drain", 300);
    ser_ready = 1'b1;
    check("bp_words", words_sent, 6);

    // Reset during bit 5 of a word.
    @(posedge clk); #1; fifo_push(11'h7FF);
    for (int k = 0; k <= 9; k++) begin
      @(negedge clk);
      if (k == 9) check("mid_pre_svalid", svalid, 1);
    end
    #1; rst = 1'b1; #1;
    check("mid_rst_outputs", {pop, svalid, sdata, sfirst, slast}, 0);
    check("mid_rst_outputs_lsb", {pop_b, svalid_b, sdata_b, sfirst_b, slast_b}, 0);
    check("mid_rst_words", words_sent, 0);
    fifo_push(11'h0AB); #1;
    check("mid_rst_pop_gated", pop, 0);
    fifo_q.delete(); empty = 1'b1;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("post_rst_idle", {pop, svalid}, 0);
    end
    @(posedge clk); #1; fifo_push(11'h3C5);
    @(negedge clk);
    check("post_rst_pop", pop, 1);
    drain("post_rst_drain", 100);
    check("post_rst_words", words_sent, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
